spi_cs_ctrl: RTL and testbench



---
 rtl/spi_cs_ctrl_pkg.sv | 18 +
 rtl/spi_cs_ctrl_if.sv | 38 +++
 rtl/spi_cs_ctrl.sv | 129 ++++++++++++
 tb/tb_spi_cs_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cs_ctrl_pkg.sv
// Shared definitions for the SPI chip-select transaction controller.
package spi_cs_ctrl_pkg;

    // Width of every data byte moved through the controller.
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StCsGap
    } state_e;

    // Counter width needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_cs_ctrl_if.sv
// User-side and master-side handshake bundle of the chip-select controller.
interface spi_cs_ctrl_if #(
    parameter int unsigned CW = 2
);
    import spi_cs_ctrl_pkg::*;

    // User request / response side
    logic [CW-1:0]     tx_count;
    logic [BYTE_W-1:0] tx_byte;
    logic              tx_dv;
    logic              tx_ready;
    logic [CW-1:0]     rx_count;
    logic              rx_dv;
    logic [BYTE_W-1:0] rx_byte;

    // Byte-engine side
    logic [BYTE_W-1:0] m_tx_byte;
    logic              m_tx_dv;
    logic              m_tx_ready;
    logic              m_rx_dv;
    logic [BYTE_W-1:0] m_rx_byte;

    // Chip select, active low
    logic              spi_cs_n;

    // Controller view
    modport slave (
        input  tx_count, tx_byte, tx_dv, m_tx_ready, m_rx_dv, m_rx_byte,
        output tx_ready, rx_count, rx_dv, rx_byte, m_tx_byte, m_tx_dv, spi_cs_n
    );

    // Environment view (user plus byte engine)
    modport master (
        output tx_count, tx_byte, tx_dv, m_tx_ready, m_rx_dv, m_rx_byte,
        input  tx_ready, rx_count, rx_dv, rx_byte, m_tx_byte, m_tx_dv, spi_cs_n
    );

endinterface

// File: rtl/spi_cs_ctrl.sv
// Chip-select transaction controller: feeds N user bytes to the SPI byte engine
// under one CS-low window, returns indexed RX bytes and enforces a CS-high gap.
module spi_cs_ctrl
    import spi_cs_ctrl_pkg::*;
#(
    parameter int unsigned MAX_BYTES_PER_CS = 2,
    parameter int unsigned CS_INACTIVE_CLKS = 1
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    spi_cs_ctrl_if.slave bus
);

    localparam int unsigned CW = cnt_width(MAX_BYTES_PER_CS);
    localparam int unsigned GW = cnt_width(CS_INACTIVE_CLKS);

    state_e            state_q;
    logic [CW-1:0]     remaining_q;
    logic              byte_done_q;
    logic [GW-1:0]     gap_q;
    logic              tx_ready_q;
    logic [CW-1:0]     rx_count_q;
    logic              rx_dv_q;
    logic [BYTE_W-1:0] rx_byte_q;
    logic [BYTE_W-1:0] m_tx_byte_q;
    logic              m_tx_dv_q;
    logic              cs_n_q;

    logic [CW-1:0]     start_count;
    logic              tx_accept;

    // Requested byte count: zero means one, oversize requests clamp to the window limit.
    always_comb begin
        start_count = bus.tx_count;
        if (bus.tx_count == '0) begin
            start_count = CW'(1);
        end else if (32'(bus.tx_count) > MAX_BYTES_PER_CS) begin
            start_count = CW'(MAX_BYTES_PER_CS);
        end
    end

    assign tx_accept = bus.tx_dv && tx_ready_q;

    // Transaction FSM with registered outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            byte_done_q <= 1'b0;
            gap_q       <= '0;
            tx_ready_q  <= 1'b0;
            rx_count_q  <= '0;
            rx_dv_q     <= 1'b0;
            rx_byte_q   <= '0;
            m_tx_byte_q <= '0;
            m_tx_dv_q   <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            m_tx_dv_q <= 1'b0;
            rx_dv_q   <= 1'b0;
            // Index advances only after the strobe so each byte carries its own index.
            if (rx_dv_q) begin
                rx_count_q <= rx_count_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (tx_accept) begin
                        remaining_q <= start_count;
                        cs_n_q      <= 1'b0;
                        m_tx_byte_q <= bus.tx_byte;
                        m_tx_dv_q   <= 1'b1;
                        rx_count_q  <= '0;
                        byte_done_q <= 1'b0;
                        tx_ready_q  <= 1'b0;
                        state_q     <= StXfer;
                    end else begin
                        tx_ready_q <= bus.m_tx_ready;
                    end
                end

                StXfer: begin
                    if (tx_accept) begin
                        m_tx_byte_q <= bus.tx_byte;
                        m_tx_dv_q   <= 1'b1;
                        byte_done_q <= 1'b0;
                        tx_ready_q  <= 1'b0;
                    end else if (bus.m_rx_dv && !byte_done_q) begin
                        // Only one RX per issued byte; guards the remaining count.
                        rx_byte_q   <= bus.m_rx_byte;
                        rx_dv_q     <= 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        byte_done_q <= 1'b1;
                        tx_ready_q  <= 1'b0;
                    end else if (byte_done_q && bus.m_tx_ready && (remaining_q == '0)) begin
                        cs_n_q     <= 1'b1;
                        gap_q      <= GW'(CS_INACTIVE_CLKS);
                        tx_ready_q <= 1'b0;
                        state_q    <= StCsGap;
                    end else begin
                        tx_ready_q <= byte_done_q && bus.m_tx_ready && (remaining_q != '0);
                    end
                end

                StCsGap: begin
                    tx_ready_q <= 1'b0;
                    if (gap_q <= GW'(1)) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.tx_ready  = tx_ready_q;
    assign bus.rx_count  = rx_count_q;
    assign bus.rx_dv     = rx_dv_q;
    assign bus.rx_byte   = rx_byte_q;
    assign bus.m_tx_byte = m_tx_byte_q;
    assign bus.m_tx_dv   = m_tx_dv_q;
    assign bus.spi_cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_cs_ctrl.sv
// Self-checking bench for spi_cs_ctrl: scripted and random transactions against a
// behavioural byte-engine model, with scoreboard queues checked by a monitor.
module tb_spi_cs_ctrl;
    import spi_cs_ctrl_pkg::*;

    localparam int unsigned MAX = 2;
    localparam int unsigned GAP = 3;
    localparam int unsigned CW  = cnt_width(MAX);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_cs_ctrl_if #(.CW(CW)) bus ();

    spi_cs_ctrl #(
        .MAX_BYTES_PER_CS(MAX),
        .CS_INACTIVE_CLKS(GAP)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard queues filled by the stimulus side
    int         exp_rx_idx[$];
    logic [7:0] exp_rx_byte[$];
    logic [7:0] exp_mosi[$];
    logic [7:0] miso_q[$];
    int         exp_win[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference rule for how many bytes a request really moves.
    function automatic int eff_count(input int c);
        if (c == 0) return 1;
        if (c > int'(MAX)) return int'(MAX);
        return c;
    endfunction

    // ---------------- monitor + byte-engine model ----------------
    initial begin : monitor
        bit busy     = 0;
        int cnt      = 0;
        int rdy_wait = 0;
        bit prev_cs  = 1;
        bit in_win   = 0;
        int high_cnt = 1000;
        int pulses   = 0;
        int rxs      = 0;
        int w;
        bus.m_tx_ready = 1'b0;
        bus.m_rx_dv    = 1'b0;
        bus.m_rx_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0; rdy_wait = 0; in_win = 0; prev_cs = 1; high_cnt = 1000;
                bus.m_tx_ready = 1'b1;
                bus.m_rx_dv    = 1'b0;
                continue;
            end
            // RX strobe must match the scoreboard and trail the engine strobe by one cycle
            if (bus.rx_dv) begin
                chk("rx_while_cs_low", 32'(bus.spi_cs_n), 0);
                chk("rx_latency", 32'(bus.m_rx_dv), 1);
                if (exp_rx_idx.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rx_unexpected: got byte 0x%0h, expected none", bus.rx_byte);
                end else begin
                    chk("rx_index", 32'(bus.rx_count), 32'(exp_rx_idx.pop_front()));
                    chk("rx_byte", 32'(bus.rx_byte), 32'(exp_rx_byte.pop_front()));
                end
            end
            // CS window bookkeeping
            if (prev_cs && !bus.spi_cs_n) begin
                chk("cs_gap_ok", 32'(high_cnt >= int'(GAP)), 1);
                in_win = 1; pulses = 0; rxs = 0; high_cnt = 0;
            end
            if (!prev_cs && bus.spi_cs_n && in_win) begin
                w = (exp_win.size() != 0) ? exp_win.pop_front() : -1;
                chk("win_pulses", 32'(pulses), 32'(w));
                chk("win_rx", 32'(rxs), 32'(w));
                in_win = 0;
            end
            if (bus.spi_cs_n) high_cnt++;
            if (bus.rx_dv) rxs++;
            prev_cs = bus.spi_cs_n;
            // Byte engine behaviour
            bus.m_rx_dv = 1'b0;
            if (bus.m_tx_dv) begin
                pulses++;
                chk("mtx_cs_low", 32'(bus.spi_cs_n), 0);
                if (exp_mosi.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL mtx_unexpected: got pulse byte 0x%0h, expected none",
                             bus.m_tx_byte);
                end else begin
                    chk("mtx_byte", 32'(bus.m_tx_byte), 32'(exp_mosi.pop_front()));
                end
                busy = 1; bus.m_tx_ready = 1'b0; cnt = $urandom_range(2, 10);
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 0;
                    bus.m_rx_dv   = 1'b1;
                    bus.m_rx_byte = (miso_q.size() != 0) ? miso_q.pop_front() : 8'hEE;
                    rdy_wait = $urandom_range(0, 2);
                    if (rdy_wait == 0) bus.m_tx_ready = 1'b1;
                end
            end else if (!bus.m_tx_ready) begin
                rdy_wait--;
                if (rdy_wait <= 0) bus.m_tx_ready = 1'b1;
            end else if (bus.spi_cs_n && ($urandom_range(0, 11) == 0)) begin
                // Stray engine strobe outside a transaction must be dropped
                bus.m_rx_dv   = 1'b1;
                bus.m_rx_byte = 8'($urandom);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int k = 0; k < 1000; k++) begin
            if (bus.tx_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout("tx_ready_wait");
    endtask

    task automatic run_txn(input int cnt, input logic [7:0] mo0, input logic [7:0] mo1,
                           input logic [7:0] mi0, input logic [7:0] mi1, input int stall,
                           input bit junk);
        logic [CW-1:0] cdrv;
        logic [7:0]    mo[2];
        logic [7:0]    mi[2];
        int            eff;
        int            hi;
        bit            ok;
        cdrv = CW'(cnt);  // the port is CW bits wide, so oversized counts wrap first
        mo[0] = mo0; mo[1] = mo1; mi[0] = mi0; mi[1] = mi1;
        eff = eff_count(int'(cdrv));
        exp_win.push_back(eff);
        for (int i = 0; i < eff; i++) begin
            exp_rx_idx.push_back(i);
            exp_rx_byte.push_back(mi[i]);
            miso_q.push_back(mi[i]);
        end
        for (int i = 0; i < eff; i++) begin
            if (i > 0) repeat (stall) @(negedge clk);
            wait_ready(ok);
            if (!ok) return;
            exp_mosi.push_back(mo[i]);
            bus.tx_dv    = 1'b1;
            bus.tx_byte  = mo[i];
            bus.tx_count = (i == 0) ? cdrv : CW'($urandom);
            @(negedge clk);
            bus.tx_dv = 1'b0;
            if (junk && !bus.tx_ready) begin
                bus.tx_dv   = 1'b1;
                bus.tx_byte = 8'($urandom);
                @(negedge clk);
                bus.tx_dv = 1'b0;
            end
        end
        hi = 0;
        while (!bus.spi_cs_n && hi < 1000) begin
            @(negedge clk);
            hi++;
        end
        if (!bus.spi_cs_n) begin
            timeout("cs_release_wait");
            return;
        end
        hi = 0;
        while (!bus.tx_ready && hi < 1000) begin
            if (junk && hi == 0) begin
                bus.tx_dv   = 1'b1;
                bus.tx_byte = 8'($urandom);
            end
            @(negedge clk);
            bus.tx_dv = 1'b0;
            hi++;
        end
        chk("gap_before_ready", 32'(hi >= int'(GAP)), 1);
    endtask

    initial begin : stimulus
        bit ok;
        bus.tx_dv    = 1'b0;
        bus.tx_byte  = 8'h00;
        bus.tx_count = '0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_cs_n", 32'(bus.spi_cs_n), 1);
        chk("rst_tx_ready", 32'(bus.tx_ready), 0);
        chk("rst_m_tx_dv", 32'(bus.m_tx_dv), 0);
        chk("rst_m_tx_byte", 32'(bus.m_tx_byte), 0);
        chk("rst_rx_dv", 32'(bus.rx_dv), 0);
        chk("rst_rx_byte", 32'(bus.rx_byte), 0);
        chk("rst_rx_count", 32'(bus.rx_count), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.tx_ready), 1);

        // Scripted cases
        run_txn(1, 8'hA5, 8'h00, 8'h3C, 8'h00, 0, 0);
        run_txn(2, 8'h12, 8'h34, 8'hF0, 8'h0F, 0, 0);
        run_txn(2, 8'h5A, 8'hC3, 8'h81, 8'h7E, 100, 0);
        run_txn(0, 8'h11, 8'h00, 8'h22, 8'h00, 0, 0);
        run_txn(7, 8'h33, 8'h44, 8'h55, 8'h66, 0, 0);
        run_txn(2, 8'h9A, 8'hBC, 8'hDE, 8'hF1, 3, 1);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            run_txn($urandom_range(0, 3), 8'($urandom), 8'($urandom), 8'($urandom),
                    8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : 0,
                    1'($urandom));
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        // Abort a two-byte transaction mid-byte
        wait_ready(ok);
        exp_mosi.push_back(8'h55);
        bus.tx_dv    = 1'b1;
        bus.tx_byte  = 8'h55;
        bus.tx_count = CW'(2);
        @(negedge clk);
        bus.tx_dv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_mosi.delete();
        exp_rx_idx.delete();
        exp_rx_byte.delete();
        miso_q.delete();
        exp_win.delete();
        @(negedge clk);
        chk("abort_cs_n", 32'(bus.spi_cs_n), 1);
        chk("abort_tx_ready", 32'(bus.tx_ready), 0);
        chk("abort_m_tx_dv", 32'(bus.m_tx_dv), 0);
        chk("abort_m_tx_byte", 32'(bus.m_tx_byte), 0);
        chk("abort_rx_dv", 32'(bus.rx_dv), 0);
        chk("abort_rx_byte", 32'(bus.rx_byte), 0);
        chk("abort_rx_count", 32'(bus.rx_count), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_txn(1, 8'hC7, 8'h00, 8'h6B, 8'h00, 0, 0);

        repeat (20) @(negedge clk);
        chk("left_rx", 32'(exp_rx_idx.size()), 0);
        chk("left_mosi", 32'(exp_mosi.size()), 0);
        chk("left_win", 32'(exp_win.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures",
                 n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
